ratio_upd_ctrl: RTL and testbench
=================================

// Module: ratio_upd_ctrl
// PURPOSE
//  Sequences ratio changes into the programmable divider's ratio sampler.
//  - Accepts a new {ratio, phase_track} from the config side on a valid/ready handshake.
//  - Range-checks the value and holds it stable on the divider-facing bus.
//  - Runs the 4-phase upd_req/upd_ack handshake. upd_ack arrives from the divider clock domain.
//  - Reports completion, range errors and handshake timeouts.
// PARAMETERS
//  RATIO_W      10    width of ratio bus
//  RATIO_MIN    2     smallest legal ratio; smaller values are rejected
//  RESET_RATIO  10'd4 value driven on ratio_out from reset; the divider samples it during its reset
//  SYNC_STAGES  2     flops in the upd_ack synchronizer, >=2
//  TIMEOUT      255   clkin cycles allowed per handshake phase before err_timeout; 8-bit counter
// PORTS
//  clkin            in   1        controller clock
//  rstb             in   1        asynchronous active-low reset
//  cfg_ratio        in   RATIO_W  requested divide ratio
//  cfg_phase_track  in   1        requested phase_track setting
//  cfg_valid        in   1        request valid
//  cfg_ready        out  1        request accepted when cfg_valid&&cfg_ready
//  ratio_out        out  RATIO_W  ratio bus to the divider
//  phase_track_out  out  1        phase_track to the divider
//  upd_req          out  1        update request to the divider; registered, glitch-free
//  upd_ack          in   1        divider acknowledge; asynchronous to clkin
//  busy             out  1        handshake in progress
//  done             out  1        1-cycle pulse: update committed, or skipped as a no-op
//  err_range        out  1        1-cycle pulse: request rejected, cfg_ratio<RATIO_MIN
//  err_timeout      out  1        1-cycle pulse: a handshake phase exceeded TIMEOUT
// BEHAVIOUR
//  Reset (rstb=0, async), output values:
//   FSM=IDLE, ratio_out=RESET_RATIO, phase_track_out=0, upd_req=0, cfg_ready=1.
//   busy, done, err_range, err_timeout all 0. Synchronizer flops and timeout counter 0.
//  ack_s = upd_ack after SYNC_STAGES clkin flops. The FSM uses only ack_s.
//  cfg_ready = (state==IDLE) && !ack_s.
//  FSM states:
//   IDLE: on accept, evaluate the request:
//    - cfg_ratio<RATIO_MIN: pulse err_range next cycle; outputs unchanged; stay in IDLE.
//    - cfg_ratio==ratio_out and cfg_phase_track==phase_track_out: pulse done next cycle; no handshake.
//    - otherwise: load ratio_out/phase_track_out; go to SETUP.
//   SETUP: 1 cycle. Buses are stable for >=1 clkin cycle before upd_req rises. Next: REQ.
//   REQ: upd_req=1. Wait for ack_s=1, then go to REL.
//   REL: upd_req=0. Wait for ack_s=0, then go to DONE.
//   DONE: pulse done for 1 cycle. Return to IDLE.
//  Outputs by state:
//   busy=1 in SETUP, REQ, REL and DONE.
//   ratio_out and phase_track_out only change on an accepted IDLE request.
//   They are frozen in all other states.
//  Latency, accept to done, both directions of upd_ack synchronized:
//   3 + 2*SYNC_STAGES + divider ack delay, in clkin cycles.
//   With an immediate ack this is >=7 cycles for SYNC_STAGES=2.
//  Timeout:
//   - Counter clears on entering REQ and on entering REL; increments each cycle in those states.
//   - At TIMEOUT: pulse err_timeout once, saturate, and keep waiting. No abort; upd_req is not dropped early.
//  Back-to-back: a new request is accepted no earlier than the cycle after DONE.
//  ack_s already high in IDLE, e.g. a stale ack: cfg_ready=0 until ack_s falls.
//  cfg_valid with cfg_ready=0: ignored, no side effects.
//  Reset mid-handshake:
//   - All state returns to reset values at once, including upd_req=0 and ratio_out=RESET_RATIO.
//   - The divider is expected to be reset alongside.
//  Error pulses and done are mutually exclusive in any cycle.
// TESTING
//  1. Reset, then release rstb: ratio_out=4, upd_req=0, cfg_ready=1; all pulses 0 for 20 cycles.
//  2. Request ratio=10, phase=1; model acks 2 cycles after req:
//     ratio_out=10 one cycle before upd_req=1; req falls only after ack_s; done pulses once; busy high throughout.
//  3. Request ratio=1, then ratio=0:
//     err_range pulses each time; ratio_out stays 4; upd_req never rises.
//  4. Request the current {ratio, phase} again: done pulses 1 cycle after accept; upd_req stays 0.
//  5. Model never acks:
//     err_timeout pulses exactly once, 255 cycles after REQ entry; upd_req stays 1.
//     A late ack then completes the handshake normally.
//  6. Assert rstb=0 while in REQ:
//     upd_req=0 and ratio_out=4 immediately (async); after release a request for 7 completes normally.

Source files
------------

// File: rtl/ratio_upd_if.sv
// ratio_upd_if: config request and divider-facing update bus of ratio_upd_ctrl.
interface ratio_upd_if #(parameter int RATIO_W = 10);
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_phase_track;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [RATIO_W-1:0] ratio_out;
    logic               phase_track_out;
    logic               upd_req;
    logic               upd_ack;
    logic               busy;
    logic               done;
    logic               err_range;
    logic               err_timeout;

    modport slave (
        input  cfg_ratio, cfg_phase_track, cfg_valid, upd_ack,
        output cfg_ready, ratio_out, phase_track_out, upd_req, busy, done, err_range, err_timeout
    );

    modport master (
        output cfg_ratio, cfg_phase_track, cfg_valid, upd_ack,
        input  cfg_ready, ratio_out, phase_track_out, upd_req, busy, done, err_range, err_timeout
    );
endinterface

// File: rtl/ratio_upd_ctrl.sv
// ratio_upd_ctrl: sequences range-checked ratio changes into the divider over a 4-phase req/ack handshake.
module ratio_upd_ctrl #(
    parameter int                 RATIO_W     = 10,
    parameter int                 RATIO_MIN   = 2,
    parameter logic [RATIO_W-1:0] RESET_RATIO = RATIO_W'(4),
    parameter int                 SYNC_STAGES = 2,
    parameter int                 TIMEOUT     = 255
) (
    input  logic       clkin,
    input  logic       rstb,
    ratio_upd_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, REQ, REL, DONE} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [RATIO_W-1:0]     ratio_q, ratio_d;
    logic                   phase_q, phase_d;
    logic                   req_q, done_q, erange_q, eto_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ack_s, accept, bad, noop, waiting, stay, to_hit;

    assign ack_s   = sync_q[SYNC_STAGES-1];
    assign accept  = bus.cfg_valid && bus.cfg_ready;
    assign bad     = bus.cfg_ratio < RATIO_W'(RATIO_MIN);
    assign noop    = bus.cfg_ratio == ratio_q && bus.cfg_phase_track == phase_q;
    assign waiting = state_q == REQ || state_q == REL;
    assign stay    = state_d == state_q;
    // Counter restarts on every state change, so each wait phase gets its own budget.
    assign cnt_d   = !stay ? 8'd0 : (waiting && cnt_q != TO) ? cnt_q + 8'd1 : cnt_q;
    assign to_hit  = waiting && stay && cnt_q == TO - 8'd1;

    always_comb begin
        state_d = state_q;
        ratio_d = ratio_q;
        phase_d = phase_q;
        case (state_q)
            IDLE:    if (accept && !bad && !noop) begin
                         state_d = SETUP;
                         ratio_d = bus.cfg_ratio;
                         phase_d = bus.cfg_phase_track;
                     end
            SETUP:   state_d = REQ;
            REQ:     if (ack_s) state_d = REL;
            REL:     if (!ack_s) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            ratio_q  <= RESET_RATIO;
            phase_q  <= 1'b0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            erange_q <= 1'b0;
            eto_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.upd_ack};
            ratio_q  <= ratio_d;
            phase_q  <= phase_d;
            req_q    <= state_d == REQ;
            done_q   <= state_d == DONE || (accept && !bad && noop);
            erange_q <= accept && bad;
            eto_q    <= to_hit;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.cfg_ready       = state_q == IDLE && !ack_s;
    assign bus.ratio_out       = ratio_q;
    assign bus.phase_track_out = phase_q;
    assign bus.upd_req         = req_q;
    assign bus.busy            = state_q != IDLE;
    assign bus.done            = done_q;
    assign bus.err_range       = erange_q;
    assign bus.err_timeout     = eto_q;
endmodule

// File: tb/tb_ratio_upd_ctrl.sv
// tb_ratio_upd_ctrl: directed and random requests against a transaction-level model with a delayed-ack divider.
module tb_ratio_upd_ctrl;
    logic clk = 1'b0;
    logic rstb;
    int   passed = 0;
    int   total  = 0;

    logic       ack_en   = 1'b1;
    logic       force_on = 1'b0;
    logic       force_val = 1'b0;
    int         ack_dly  = 0;
    logic [9:0] cur      = 10'd4;
    logic       curp     = 1'b0;

    ratio_upd_if u ();
    ratio_upd_ctrl dut (.clkin(clk), .rstb(rstb), .bus(u));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Divider model: mirrors upd_req onto upd_ack ack_dly cycles after it sees a change.
    initial begin
        int dcnt = 0;
        u.upd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (force_on) u.upd_ack = force_val;
            else if (!ack_en) dcnt = 0;
            else if (u.upd_req !== u.upd_ack) begin
                if (dcnt >= ack_dly) begin
                    u.upd_ack = u.upd_req;
                    dcnt = 0;
                end else dcnt++;
            end else dcnt = 0;
        end
    end

    function automatic logic [31:0] outs();
        return {16'd0, u.busy, u.upd_req, u.done, u.err_range, u.err_timeout, u.phase_track_out, u.ratio_out};
    endfunction

    function automatic logic [31:0] mk(input logic b, input logic rq, input logic dn, input logic er,
                                       input logic et, input logic ph, input logic [9:0] ra);
        return {16'd0, b, rq, dn, er, et, ph, ra};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [9:0] r, input logic p);
        int n = 0;
        while (u.cfg_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, u.cfg_ready}, 32'd1);
        u.cfg_ratio = r;
        u.cfg_phase_track = p;
        u.cfg_valid = 1'b1;
        @(negedge clk);
        u.cfg_valid = 1'b0;
    endtask

    // Accept-to-done latency is 3 + 2*SYNC_STAGES plus d cycles of ack delay in each direction.
    task automatic req_check(input logic [9:0] r, input logic p, input int d);
        ack_dly = d;
        send(r, p);
        if (r < 10'd2) begin
            chk("err_range", outs(), mk(0, 0, 0, 1, 0, curp, cur));
            @(negedge clk);
            chk("err_range_end", outs(), mk(0, 0, 0, 0, 0, curp, cur));
        end else if (r == cur && p == curp) begin
            chk("noop", outs(), mk(0, 0, 1, 0, 0, curp, cur));
            @(negedge clk);
            chk("noop_end", outs(), mk(0, 0, 0, 0, 0, curp, cur));
        end else begin
            cur = r;
            curp = p;
            for (int n = 1; n <= 8 + 2 * d; n++) begin
                chk("hs", outs(), mk(1, n >= 2 && n <= 4 + d, n == 8 + 2 * d, 0, 0, p, r));
                @(negedge clk);
            end
            chk("hs_end", outs(), mk(0, 0, 0, 0, 0, p, r));
            chk("hs_ready", {31'd0, u.cfg_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [9:0] r;
        logic       p;
        int         k;
        u.cfg_ratio = '0;
        u.cfg_phase_track = 1'b0;
        u.cfg_valid = 1'b0;
        rstb = 1'b1;
        #1 rstb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", outs(), mk(0, 0, 0, 0, 0, 0, 10'd4));
        chk("reset_ready", {31'd0, u.cfg_ready}, 32'd1);
        rstb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", outs(), mk(0, 0, 0, 0, 0, 0, 10'd4));
        end

        req_check(10'd10, 1'b1, 2);
        req_check(10'd1, 1'b0, 0);
        req_check(10'd0, 1'b1, 0);
        req_check(10'd10, 1'b1, 0);

        force_on = 1'b1;
        force_val = 1'b1;
        repeat (3) @(negedge clk);
        chk("stale_ready", {31'd0, u.cfg_ready}, 32'd0);
        u.cfg_ratio = cur ^ 10'h200;
        u.cfg_phase_track = ~curp;
        u.cfg_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stale_ignored", outs(), mk(0, 0, 0, 0, 0, curp, cur));
        end
        u.cfg_valid = 1'b0;
        force_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_cleared", {31'd0, u.cfg_ready}, 32'd1);
        force_on = 1'b0;

        ack_en = 1'b0;
        r = (cur == 10'd500) ? 10'd501 : 10'd500;
        send(r, 1'b0);
        for (int n = 1; n <= 300; n++) begin
            chk("timeout", outs(), mk(1, n >= 2, 0, 0, n == 257, 0, r));
            @(negedge clk);
        end
        ack_en = 1'b1;
        ack_dly = 0;
        k = 0;
        while (u.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            chk("late_no_timeout", {31'd0, u.err_timeout}, 32'd0);
            k++;
        end
        chk("late_done", {31'd0, u.done}, 32'd1);
        @(negedge clk);
        chk("late_idle", outs(), mk(0, 0, 0, 0, 0, 0, r));
        cur = r;
        curp = 1'b0;

        ack_en = 1'b0;
        send(10'd9, 1'b1);
        @(negedge clk);
        chk("rst_in_req", {31'd0, u.upd_req}, 32'd1);
        rstb = 1'b0;
        #1;
        chk("rst_async", outs(), mk(0, 0, 0, 0, 0, 0, 10'd4));
        chk("rst_ready", {31'd0, u.cfg_ready}, 32'd1);
        cur = 10'd4;
        curp = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        req_check(10'd7, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin r = 10'($urandom_range(0, 1)); p = 1'($urandom_range(0, 1)); end
                1: begin r = cur; p = curp; end
                default: begin r = 10'($urandom_range(2, 1023)); p = 1'($urandom_range(0, 1)); end
            endcase
            req_check(r, p, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
